// File: rtl/noc_pkg.sv
// Shared types and flit-field helpers for the NoC output arbiter.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  function automatic int unsigned head_bit(int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned tail_bit(int unsigned width);
    return width - 2;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
)
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] masked;

  // Lower copy masked below ptr, so the search wraps into the upper copy.
  always_comb begin
    masked = {req, req};
    for (int j = 0; j < int'(N); j++) begin
      if (j < int'(ptr)) masked[j] = 1'b0;
    end
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < 2 * int'(N); j++) begin
      if (!any && masked[j]) begin
        any = 1'b1;
        idx = IDX_W'(j % int'(N));
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Round-robin wormhole arbiter sharing one router output between N inputs.
// Optional per-input head-flit counters when NOC_ARB_STATS_EN is defined.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_flit,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_flit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic                 err,
  input  logic                 stat_clr,
  output logic [N*CNT_W-1:0]   stat_pkt_cnt
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HB    = head_bit(WIDTH);
  localparam int unsigned TB    = tail_bit(WIDTH);

  arb_state_e       state, state_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] sel, sel_n;
  logic [IDX_W-1:0] cur_idx;
  logic             err_n;
  logic             xfer;

  logic [WIDTH-1:0] flits [N];
  logic [N-1:0]     heads;
  logic [N-1:0]     cand;
  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             idle_bad;

  function automatic logic [IDX_W-1:0] ptr_inc(logic [IDX_W-1:0] p);
    return (int'(p) == int'(N) - 1) ? '0 : IDX_W'(int'(p) + 1);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      flits[i] = in_flit[i*WIDTH +: WIDTH];
      heads[i] = flits[i][HB];
    end
    cand     = in_valid & heads;
    idle_bad = |(in_valid & ~heads);
  end

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
    .req (cand),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Flit mux, handshake and next-state logic.
  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    sel_n     = sel;
    err_n     = err;
    out_valid = 1'b0;
    grant     = '0;
    in_ready  = '0;
    cur_idx   = (state == IDLE) ? pick_idx : sel;
    out_flit  = flits[cur_idx];

    if (!rst) begin
      if (state == IDLE) begin
        out_valid = pick_any;
        grant     = pick_gnt;
      end else begin
        out_valid  = in_valid[sel];
        grant[sel] = 1'b1;
      end
      if (state != IDLE || pick_any) in_ready[cur_idx] = out_ready;
    end

    xfer = out_valid & out_ready;

    unique case (state)
      IDLE: begin
        if (idle_bad) err_n = 1'b1;
        if (pick_any) begin
          // An untaken offer is frozen in HOLD so later arrivals cannot steal it.
          if (!xfer) begin
            sel_n   = pick_idx;
            state_n = HOLD;
          end else if (out_flit[TB]) begin
            rr_ptr_n = ptr_inc(pick_idx);
          end else begin
            sel_n   = pick_idx;
            state_n = LOCKED;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          if (out_flit[TB]) begin
            state_n  = IDLE;
            rr_ptr_n = ptr_inc(sel);
          end else begin
            state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (out_flit[HB]) err_n = 1'b1;
          if (out_flit[TB]) begin
            state_n  = IDLE;
            rr_ptr_n = ptr_inc(sel);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      sel    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      sel    <= sel_n;
      err    <= err_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef NOC_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [N];

  // Saturating head-flit counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < int'(N); i++) cnt[i] <= '0;
    end else if (xfer && out_flit[HB] && (cnt[cur_idx] != '1)) begin
      cnt[cur_idx] <= cnt[cur_idx] + CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) stat_pkt_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_pkt_cnt    = '0;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter (N=4, WIDTH=64, CNT_W=2).
module tb_noc_output_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N*WIDTH-1:0]   in_flit;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_flit;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         grant;
  logic                 busy;
  logic                 err;
  logic                 stat_clr;
  logic [N*CNT_W-1:0]   stat_pkt_cnt;

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] flit;
  } exp_t;

  exp_t             sb_q [$];
  logic [WIDTH-1:0] src_q [N][$];
  logic [N-1:0]     fire;
  int unsigned      exp_cnt [N];
  int               checks   = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  noc_output_arbiter #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .grant        (grant),
    .busy         (busy),
    .err          (err),
    .stat_clr     (stat_clr),
    .stat_pkt_cnt (stat_pkt_cnt)
  );

  function automatic logic [WIDTH-1:0] mk(logic h, logic t, int unsigned port, int unsigned seq);
    return {h, t, 30'd0, 16'(port), 16'(seq)};
  endfunction

  function automatic logic [N*CNT_W-1:0] exp_stats();
    logic [N*CNT_W-1:0] v;
    v = '0;
`ifdef NOC_ARB_STATS_EN
    for (int i = 0; i < int'(N); i++) v[i*CNT_W +: CNT_W] = CNT_W'(exp_cnt[i]);
`endif
    return v;
  endfunction

  // Queue a flit at an input and its expected appearance at the output.
  task automatic push(int unsigned port, logic [WIDTH-1:0] f);
    exp_t e;
    e.gnt  = N'(1) << port;
    e.flit = f;
    src_q[port].push_back(f);
    sb_q.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < int'(N); i++) begin
      in_valid[i] = (src_q[i].size() > 0);
      in_flit[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // Mid-cycle sample: record handshakes and consume the scoreboard on transfers.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    fire = in_valid & in_ready;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got grant=%b flit=%h, required no transfer", grant, out_flit);
      end else begin
        e = sb_q.pop_front();
        if (grant !== e.gnt || out_flit !== e.flit) begin
          failures++;
          $display("FAIL sb_xfer: got grant=%b flit=%h, required grant=%b flit=%h",
                   grant, out_flit, e.gnt, e.flit);
        end
        if (e.flit[WIDTH-1]) begin
          for (int i = 0; i < int'(N); i++)
            if (e.gnt[i] && exp_cnt[i] < SAT) exp_cnt[i]++;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++)
      if (fire[i]) void'(src_q[i].pop_front());
    apply();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    in_valid  = '1;
    for (int i = 0; i < int'(N); i++) in_flit[i*WIDTH +: WIDTH] = mk(1'b1, 1'b1, i, 0);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== '0 || out_valid !== 1'b0 || grant !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got in_ready=%b out_valid=%b grant=%b, required 0/0/0",
                 in_ready, out_valid, grant);
      end
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    out_ready = 1'b0;
    in_valid = '0;
    in_flit  = '0;
    sample();
    checks++;
    if (stat_pkt_cnt !== '0 || busy !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got stat=%h busy=%b err=%b out_valid=%b, required 0/0/0/0",
               stat_pkt_cnt, busy, err, out_valid);
    end
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [3];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0100;
    exp_g[2] = 4'b1000;
    push(0, mk(1'b1, 1'b1, 0, 1));
    push(2, mk(1'b1, 1'b1, 2, 1));
    push(3, mk(1'b1, 1'b1, 3, 1));
    out_ready = 1'b1;
    apply();
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (grant !== exp_g[c]) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b, required %b", c, grant, exp_g[c]);
      end
      advance();
    end
    sample();
    checks++;
    if (out_valid !== 1'b0 || grant !== '0) begin
      failures++;
      $display("FAIL rr_drain: got out_valid=%b grant=%b, required 0/0000", out_valid, grant);
    end
    advance();
  endtask

  task automatic test_lock();
    push(1, mk(1'b1, 1'b0, 1, 1));
    push(1, mk(1'b0, 1'b0, 1, 2));
    push(1, mk(1'b0, 1'b1, 1, 3));
    push(2, mk(1'b1, 1'b1, 2, 2));
    apply();
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (in_ready[2] !== 1'b0 || grant !== 4'b0010 || (c == 1 && busy !== 1'b1)) begin
        failures++;
        $display("FAIL lock_block[%0d]: got in_ready=%b grant=%b busy=%b, required in_ready[2]=0 grant=0010",
                 c, in_ready, grant, busy);
      end
      advance();
    end
    sample();
    checks++;
    if (grant !== 4'b0100 || in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL lock_next: got grant=%b in_ready=%b, required 0100/0100", grant, in_ready);
    end
    advance();
  endtask

  task automatic test_rr_wrap();
    push(3, mk(1'b1, 1'b1, 3, 2));
    push(0, mk(1'b1, 1'b1, 0, 2));
    apply();
    sample();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_first: got %b, required 1000", grant);
    end
    advance();
    sample();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_second: got %b, required 0001", grant);
    end
    advance();
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] f0;
    f0 = mk(1'b1, 1'b1, 0, 3);
    out_ready = 1'b0;
    push(0, f0);
    apply();
    sample();
    checks++;
    if (grant !== 4'b0001 || out_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_offer: got grant=%b out_valid=%b busy=%b, required 0001/1/0", grant, out_valid, busy);
    end
    advance();
    push(3, mk(1'b1, 1'b1, 3, 3));
    apply();
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (busy !== 1'b1 || grant !== 4'b0001 || out_flit !== f0 || in_ready !== '0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got busy=%b grant=%b flit=%h in_ready=%b, required 1/0001/%h/0000",
                 c, busy, grant, out_flit, in_ready, f0);
      end
      advance();
    end
    out_ready = 1'b1;
    sample();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL hold_release: got %b, required 0001", grant);
    end
    advance();
    sample();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL hold_after: got %b, required 1000", grant);
    end
    advance();
  endtask

  task automatic test_stats_err();
    for (int k = 0; k < 5; k++) push(1, mk(1'b1, 1'b1, 1, 10 + k));
    apply();
    for (int k = 0; k < 5; k++) begin
      sample();
      advance();
    end
    sample();
    checks++;
    if (out_valid !== 1'b0 || stat_pkt_cnt !== exp_stats()) begin
      failures++;
      $display("FAIL stat_sat: got out_valid=%b stat=%h, required 0/%h", out_valid, stat_pkt_cnt, exp_stats());
    end
    advance();
    push(1, mk(1'b1, 1'b1, 1, 20));
    stat_clr = 1'b1;
    apply();
    sample();
    advance();
    stat_clr = 1'b0;
    for (int i = 0; i < int'(N); i++) exp_cnt[i] = 0;
    sample();
    checks++;
    if (stat_pkt_cnt !== exp_stats() || err !== 1'b0) begin
      failures++;
      $display("FAIL stat_clr: got stat=%h err=%b, required %h/0", stat_pkt_cnt, err, exp_stats());
    end
    advance();
    src_q[2].push_back(mk(1'b0, 1'b0, 2, 30));
    apply();
    sample();
    checks++;
    if (out_valid !== 1'b0 || grant !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL body_idle: got out_valid=%b grant=%b err=%b, required 0/0000/0", out_valid, grant, err);
    end
    advance();
    src_q[2].delete();
    apply();
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL err_sticky[%0d]: got %b, required 1", c, err);
      end
      advance();
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_rst: got err=%b busy=%b, required 0/0", err, busy);
    end
    advance();
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) exp_cnt[i] = 0;
    fire = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_rr_wrap();
    test_hold();
    test_stats_err();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending transfers, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
